// File: rtl/tick_prescaler.sv
// tick_prescaler: multi-rate power-of-two tick generator with square output,
// wrapping tick counter, continuous/one-shot modes, pause/resume and rate
// changes that only land on a period boundary.
module tick_prescaler #(
  parameter int NB_COUNT   = 32,
  parameter int NB_SEL     = 2,
  parameter int BASE_SHIFT = 22,  // BASE_SHIFT + 2**NB_SEL - 1 must fit in NB_COUNT
  parameter int NB_TICKS   = 8
) (
  input  logic                clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic [NB_SEL-1:0]   i_sel,
  input  logic                i_oneshot,
  input  logic                i_start,
  input  logic                i_clear,
  output logic                o_tick,
  output logic                o_square,
  output logic                o_busy,
  output logic [NB_TICKS-1:0] o_tick_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                r_state;
  logic [NB_COUNT-1:0]   r_cnt;
  logic [NB_SEL-1:0]     r_sel;
  logic                  r_mode;
  logic                  r_tick;
  logic                  r_square;
  logic [NB_TICKS-1:0]   r_tick_count;

  state_t                w_state_nx;
  logic [NB_COUNT-1:0]   w_cnt_nx;
  logic [NB_SEL-1:0]     w_sel_nx;
  logic                  w_mode_nx;
  logic                  w_tick_nx;
  logic                  w_square_nx;
  logic [NB_TICKS-1:0]   w_count_nx;

  logic [NB_COUNT-1:0]   w_limit;
  logic                  w_at_end;

  // Period limit comes from the registered select only, so a mid-period
  // change of i_sel cannot move the current period end.
  assign w_limit  = (NB_COUNT'(1) << (BASE_SHIFT + int'(r_sel))) - NB_COUNT'(1);
  // >= so an out-of-range counter still terminates the period.
  assign w_at_end = (r_cnt >= w_limit);

  // Next-state and datapath decode; soft clear overrides normal operation.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_sel_nx    = r_sel;
    w_mode_nx   = r_mode;
    w_tick_nx   = 1'b0;
    w_square_nx = r_square;
    w_count_nx  = r_tick_count;
    if (i_clear) begin
      w_state_nx  = S_IDLE;
      w_cnt_nx    = '0;
      w_sel_nx    = '0;
      w_mode_nx   = 1'b0;
      w_square_nx = 1'b0;
      w_count_nx  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable && (!i_oneshot || i_start)) begin
            w_state_nx = S_RUN;
            w_cnt_nx   = '0;
            w_sel_nx   = i_sel;
            w_mode_nx  = i_oneshot;
          end
        end
        S_RUN, S_PAUSE: begin
          // Resuming from PAUSE counts on the same edge, so each paused
          // cycle delays the tick by exactly one cycle.
          if (!i_enable) begin
            w_state_nx = S_PAUSE;
          end else if (w_at_end) begin
            w_cnt_nx    = '0;
            w_tick_nx   = 1'b1;
            w_square_nx = ~r_square;
            w_count_nx  = r_tick_count + NB_TICKS'(1);
            w_sel_nx    = i_sel;
            w_state_nx  = r_mode ? S_IDLE : S_RUN;
          end else begin
            w_cnt_nx   = r_cnt + NB_COUNT'(1);
            w_state_nx = S_RUN;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_mode       <= 1'b0;
      r_tick       <= 1'b0;
      r_square     <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_sel        <= w_sel_nx;
      r_mode       <= w_mode_nx;
      r_tick       <= w_tick_nx;
      r_square     <= w_square_nx;
      r_tick_count <= w_count_nx;
    end
  end

  assign o_tick       = r_tick;
  assign o_square     = r_square;
  assign o_busy       = (r_state != S_IDLE);
  assign o_tick_count = r_tick_count;

endmodule

// File: tb/tb_tick_prescaler.sv
// Scoreboard bench for tick_prescaler: stimulus pushes expected ticks
// (edge number, square, count, busy); a monitor pops one per observed tick.
module tb_tick_prescaler;
  localparam int NB_COUNT   = 32;
  localparam int NB_SEL     = 2;
  localparam int BASE_SHIFT = 2;
  localparam int NB_TICKS   = 4;

  logic                clock = 1'b0;
  logic                i_reset_n, i_enable, i_oneshot, i_start, i_clear;
  logic [NB_SEL-1:0]   i_sel;
  logic                o_tick, o_square, o_busy;
  logic [NB_TICKS-1:0] o_tick_count;

  typedef struct {
    int   cyc;
    logic sq;
    int   cnt;
    logic busy;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   k;

  tick_prescaler #(
    .NB_COUNT(NB_COUNT), .NB_SEL(NB_SEL), .BASE_SHIFT(BASE_SHIFT), .NB_TICKS(NB_TICKS)
  ) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_sel(i_sel),
    .i_oneshot(i_oneshot), .i_start(i_start), .i_clear(i_clear),
    .o_tick(o_tick), .o_square(o_square), .o_busy(o_busy), .o_tick_count(o_tick_count)
  );

  always #5 clock = ~clock;

  // Edge counter: at a negedge, cyc is the number of the preceding posedge.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic exp_tick(input int c, input logic sq, input int cnt, input logic busy);
    exp_t e;
    e.cyc = c; e.sq = sq; e.cnt = cnt; e.busy = busy;
    q.push_back(e);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0; i_enable = 1'b0; i_start = 1'b0; i_clear = 1'b0;
    i_oneshot = 1'b0; i_sel = '0;
    tick_n(2);
    i_reset_n = 1'b1;
    tick_n(1);
  endtask

  // Monitor: every tick must match the head of the scoreboard.
  always @(negedge clock) begin
    if (o_tick === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_tick cyc=%0d actual=1 required=0", cyc);
      end else begin
        m_e = q.pop_front();
        chk("tick_cyc",   cyc,                m_e.cyc);
        chk("tick_sq",    int'(o_square),     int'(m_e.sq));
        chk("tick_count", int'(o_tick_count), m_e.cnt);
        chk("tick_busy",  int'(o_busy),       int'(m_e.busy));
      end
    end
  end

  initial begin
    // Reset held 3 cycles with enable high.
    i_reset_n = 1'b0; i_enable = 1'b1; i_sel = 2'd0; i_oneshot = 1'b0;
    i_start = 1'b0; i_clear = 1'b0;
    tick_n(3);
    chk("rst_tick",  int'(o_tick),       0);
    chk("rst_sq",    int'(o_square),     0);
    chk("rst_busy",  int'(o_busy),       0);
    chk("rst_count", int'(o_tick_count), 0);
    i_reset_n = 1'b1;
    k = cyc + 1;
    exp_tick(k + 4, 1'b1, 1, 1'b1);
    exp_tick(k + 8, 1'b0, 2, 1'b1);
    tick_n(1);
    chk("rel_busy", int'(o_busy), 1);
    wait_cyc(k + 9);
    chk("rst_pending", q.size(), 0);

    // Continuous, sel=1: ticks every 8 edges.
    do_reset();
    i_sel = 2'd1; i_enable = 1'b1;
    k = cyc + 1;
    exp_tick(k + 8,  1'b1, 1, 1'b1);
    exp_tick(k + 16, 1'b0, 2, 1'b1);
    exp_tick(k + 24, 1'b1, 3, 1'b1);
    wait_cyc(k + 25);
    chk("cont_pending", q.size(), 0);

    // Rate change 0 -> 3 lands only after the next tick.
    do_reset();
    i_sel = 2'd0; i_enable = 1'b1;
    k = cyc + 1;
    exp_tick(k + 4,  1'b1, 1, 1'b1);
    exp_tick(k + 8,  1'b0, 2, 1'b1);
    exp_tick(k + 40, 1'b1, 3, 1'b1);
    wait_cyc(k + 6);
    i_sel = 2'd3;
    wait_cyc(k + 41);
    chk("rate_pending", q.size(), 0);

    // Pause for 5 cycles mid-period at sel=1.
    do_reset();
    i_sel = 2'd1; i_enable = 1'b1;
    k = cyc + 1;
    exp_tick(k + 13, 1'b1, 1, 1'b1);
    exp_tick(k + 21, 1'b0, 2, 1'b1);
    wait_cyc(k + 3);
    i_enable = 1'b0;
    wait_cyc(k + 6);
    chk("pause_busy", int'(o_busy), 1);
    wait_cyc(k + 8);
    i_enable = 1'b1;
    wait_cyc(k + 22);
    chk("pause_pending", q.size(), 0);

    // One-shot, sel=2: single tick, ignored retrigger, restart after tick.
    do_reset();
    i_sel = 2'd2; i_oneshot = 1'b1; i_enable = 1'b1; i_start = 1'b1;
    k = cyc + 1;
    exp_tick(k + 16, 1'b1, 1, 1'b0);
    exp_tick(k + 33, 1'b0, 2, 1'b0);
    tick_n(1);
    i_start = 1'b0;
    chk("os_busy", int'(o_busy), 1);
    wait_cyc(k + 5);
    i_start = 1'b1;
    tick_n(1);
    i_start = 1'b0;
    wait_cyc(k + 16);
    i_start = 1'b1;
    tick_n(1);
    i_start = 1'b0;
    chk("os_restart_busy", int'(o_busy), 1);
    wait_cyc(k + 40);
    chk("os_idle_busy", int'(o_busy), 0);
    chk("os_pending", q.size(), 0);

    // Wrap at sel=0, then clear mid-period.
    do_reset();
    i_sel = 2'd0; i_enable = 1'b1;
    k = cyc + 1;
    for (int i = 1; i <= 17; i++)
      exp_tick(k + 4 * i, logic'(i % 2), i % 16, 1'b1);
    wait_cyc(k + 64);
    chk("wrap_count", int'(o_tick_count), 0);
    wait_cyc(k + 69);
    i_clear = 1'b1;
    tick_n(1);
    i_clear = 1'b0; i_enable = 1'b0;
    chk("clr_busy",  int'(o_busy),       0);
    chk("clr_count", int'(o_tick_count), 0);
    chk("clr_sq",    int'(o_square),     0);
    chk("clr_tick",  int'(o_tick),       0);
    wait_cyc(k + 80);
    chk("clr_pending", q.size(), 0);

    // Clear and reset together give the reset result.
    i_enable = 1'b1;
    k = cyc + 1;
    exp_tick(k + 4, 1'b1, 1, 1'b1);
    wait_cyc(k + 6);
    i_reset_n = 1'b0; i_clear = 1'b1;
    tick_n(1);
    i_reset_n = 1'b1; i_clear = 1'b0; i_enable = 1'b0;
    chk("rc_busy",  int'(o_busy),       0);
    chk("rc_count", int'(o_tick_count), 0);
    chk("rc_sq",    int'(o_square),     0);
    tick_n(6);
    chk("rc_pending", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
